// File: rtl/rapids_pkg.sv
// Shared types for the instruction prefetch slice: the fetch FSM states and the
// queue entry that carries a fetched word together with its PC and fault flag.
package rapids_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic {
      PF_FETCH,
      PF_FAULT
   } pf_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc;
      logic              segv;
   } pf_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of prefetch entries with a flush input; the head reads as zero
// whenever the queue is empty.
module instr_fifo
   import rapids_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  pf_entry_t              i_data,
   input  logic                   i_pop,
   output pf_entry_t              o_head,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   pf_entry_t     r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == (AW+1)'(DEPTH));
   // A flush discards whatever push or pop coincides with it.
   assign w_push  = i_push && !w_full && !i_flush;
   assign w_pop   = i_pop && !w_empty && !i_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   assign o_head  = w_empty ? '0 : r_mem[r_rd];
   assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: sequential word fetch from the MMU, queued with PCs,
// presented to controlpath over valid/ready; handles redirects and fetch faults.
module instr_prefetch
   import rapids_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic              mem_req,
   output logic [WORD_W-1:0] mem_addr,
   input  logic [WORD_W-1:0] mem_instr,
   input  logic              mem_wait,
   input  logic              mem_segv,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_instr,
   output logic [WORD_W-1:0] out_pc,
   output logic              out_segv
);

   localparam int unsigned       CW       = $clog2(DEPTH) + 1;
   localparam logic [WORD_W-1:0] ALIGN_M  = ~32'h0000_0003;
   localparam logic [WORD_W-1:0] RST_ADDR = RESET_PC & ALIGN_M;

   pf_state_t         r_state;
   logic [WORD_W-1:0] r_pc;
   logic [CW-1:0]     w_count;
   logic              w_done;
   logic              w_pop;
   pf_entry_t         w_entry;
   pf_entry_t         w_head;

   // No pop bypass: a full queue never requests, even while it is being drained.
   assign mem_req  = !rst && (r_state == PF_FETCH) && !redirect && (w_count < CW'(DEPTH));
   assign mem_addr = r_pc;
   assign w_done   = mem_req && !mem_wait;

   assign w_entry.instr = mem_segv ? '0 : mem_instr;
   assign w_entry.pc    = r_pc;
   assign w_entry.segv  = mem_segv;

   assign out_valid = (w_count != '0);
   assign w_pop     = out_valid && out_ready && !redirect;
   assign out_instr = w_head.instr;
   assign out_pc    = w_head.pc;
   assign out_segv  = w_head.segv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= PF_FETCH;
         r_pc    <= RST_ADDR;
      end else if (redirect) begin
         r_state <= PF_FETCH;
         r_pc    <= redirect_pc & ALIGN_M;
      end else if (w_done) begin
         r_pc <= r_pc + WORD_W'(INSTR_BYTES);
         if (mem_segv) r_state <= PF_FAULT;
      end
   end

   instr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect),
      .i_push  (w_done),
      .i_data  (w_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: a scoreboard queue of expected entries is
// filled as each fetch sequence is started and drained on every accepted pop.
module tb_instr_prefetch;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_instr;
   logic        mem_wait;
   logic        mem_segv;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_segv;
   logic        segv_en;
   logic [31:0] segv_addr;

   typedef struct {
      logic [31:0] pc;
      logic        segv;
   } exp_t;

   exp_t exp_q[$];
   int   errs   = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // MMU model: word content is a fixed function of its address.
   assign mem_instr = mem_addr ^ KEY;
   assign mem_segv  = segv_en && (mem_addr == segv_addr);

   instr_prefetch #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_instr   (mem_instr),
      .mem_wait    (mem_wait),
      .mem_segv    (mem_segv),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_segv    (out_segv)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic segv);
      exp_t e;
      e.pc   = pc;
      e.segv = segv;
      exp_q.push_back(e);
   endtask

   // Advance to the falling edge and score any handshake that the next rising edge takes.
   task automatic to_neg();
      exp_t e;
      @(negedge clk);
      if (!rst && !redirect && out_valid === 1'b1 && out_ready) begin
         chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", out_pc, e.pc);
            chk("sb_instr", out_instr, e.segv ? 32'h0 : (e.pc ^ KEY));
            chk("sb_segv", 32'(out_segv), 32'(e.segv));
         end
      end
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      to_neg();
      to_pos();
   endtask

   task automatic redir(input logic [31:0] pc);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      redirect    = 1'b1;
      redirect_pc = pc;
      step();
      redirect    = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      mem_wait    = 1'b0;
      out_ready   = 1'b1;
      segv_en     = 1'b0;
      segv_addr   = '0;

      // 1: reset values, then sequential fetch from RESET_PC
      to_neg();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_segv", 32'(out_segv), 32'd0);
      to_pos();
      step();
      rst = 1'b0;
      push_exp(32'h100, 1'b0);
      push_exp(32'h104, 1'b0);
      push_exp(32'h108, 1'b0);
      to_neg();
      chk("t1_first_addr", mem_addr, 32'h100);
      chk("t1_first_req", 32'(mem_req), 32'd1);
      chk("t1_latency_valid", 32'(out_valid), 32'd0);
      to_pos();
      for (int i = 0; i < 3; i++) begin
         to_neg();
         chk("t1_stream_valid", 32'(out_valid), 32'd1);
         to_pos();
      end
      out_ready = 1'b0;

      // 2: fill to DEPTH, no pop bypass, single pop then single refill
      redir(32'h100);
      push_exp(32'h100, 1'b0);
      for (int i = 0; i < 4; i++) step();
      for (int i = 0; i < 2; i++) begin
         to_neg();
         chk("t2_full_req", 32'(mem_req), 32'd0);
         chk("t2_full_addr", mem_addr, 32'h110);
         chk("t2_head_pc", out_pc, 32'h100);
         to_pos();
      end
      out_ready = 1'b1;
      to_neg();
      chk("t2_nobypass_req", 32'(mem_req), 32'd0);
      to_pos();
      out_ready = 1'b0;
      to_neg();
      chk("t2_refill_req", 32'(mem_req), 32'd1);
      chk("t2_refill_addr", mem_addr, 32'h110);
      chk("t2_next_head", out_pc, 32'h104);
      to_pos();
      to_neg();
      chk("t2_refull_req", 32'(mem_req), 32'd0);
      chk("t2_refull_addr", mem_addr, 32'h114);
      to_pos();

      // 3: wait states hold the address and suppress the push
      mem_wait  = 1'b1;
      out_ready = 1'b1;
      redir(32'h200);
      push_exp(32'h200, 1'b0);
      push_exp(32'h204, 1'b0);
      push_exp(32'h208, 1'b0);
      for (int i = 0; i < 3; i++) begin
         to_neg();
         chk("t3_wait_addr", mem_addr, 32'h200);
         chk("t3_wait_nopush", 32'(out_valid), 32'd0);
         to_pos();
      end
      mem_wait = 1'b0;
      to_neg();
      chk("t3_release_addr", mem_addr, 32'h200);
      to_pos();
      for (int i = 0; i < 3; i++) begin
         to_neg();
         chk("t3_stream_valid", 32'(out_valid), 32'd1);
         to_pos();
      end
      out_ready = 1'b0;

      // 4: redirect flushes a partly filled queue, unaligned target
      redir(32'h300);
      for (int i = 0; i < 3; i++) step();
      redirect    = 1'b1;
      redirect_pc = 32'h403;
      to_neg();
      chk("t4_pre_valid", 32'(out_valid), 32'd1);
      chk("t4_pre_head", out_pc, 32'h300);
      chk("t4_redirect_req", 32'(mem_req), 32'd0);
      to_pos();
      redirect = 1'b0;
      to_neg();
      chk("t4_flushed_valid", 32'(out_valid), 32'd0);
      chk("t4_new_addr", mem_addr, 32'h400);
      chk("t4_new_req", 32'(mem_req), 32'd1);
      to_pos();
      out_ready = 1'b1;
      push_exp(32'h400, 1'b0);
      step();
      out_ready = 1'b0;

      // 5: fetch fault queues one marker behind older words and halts
      segv_addr = 32'h50C;
      segv_en   = 1'b1;
      out_ready = 1'b1;
      redir(32'h500);
      push_exp(32'h500, 1'b0);
      push_exp(32'h504, 1'b0);
      push_exp(32'h508, 1'b0);
      push_exp(32'h50C, 1'b1);
      for (int i = 0; i < 4; i++) step();
      to_neg();
      chk("t5_fault_req", 32'(mem_req), 32'd0);
      chk("t5_fault_head", 32'(out_segv), 32'd1);
      to_pos();
      for (int i = 0; i < 2; i++) begin
         to_neg();
         chk("t5_halt_req", 32'(mem_req), 32'd0);
         chk("t5_halt_valid", 32'(out_valid), 32'd0);
         to_pos();
      end
      segv_en = 1'b0;
      redir(32'h600);
      push_exp(32'h600, 1'b0);
      to_neg();
      chk("t5_resume_req", 32'(mem_req), 32'd1);
      chk("t5_resume_addr", mem_addr, 32'h600);
      to_pos();
      step();
      out_ready = 1'b0;

      // 6: address wrap, then reset in the middle of a stall
      out_ready = 1'b1;
      redir(32'hFFFF_FFF8);
      push_exp(32'hFFFF_FFF8, 1'b0);
      push_exp(32'hFFFF_FFFC, 1'b0);
      push_exp(32'h0000_0000, 1'b0);
      for (int i = 0; i < 4; i++) step();
      mem_wait  = 1'b1;
      out_ready = 1'b0;
      step();
      to_neg();
      chk("t6_stall_head", out_pc, 32'h0000_0004);
      chk("t6_stall_addr", mem_addr, 32'h0000_0008);
      to_pos();
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("t6_rst_req", 32'(mem_req), 32'd0);
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_pc", out_pc, 32'd0);
      chk("t6_rst_instr", out_instr, 32'd0);
      chk("t6_rst_segv", 32'(out_segv), 32'd0);
      to_pos();
      rst       = 1'b0;
      mem_wait  = 1'b0;
      out_ready = 1'b1;
      push_exp(32'h100, 1'b0);
      to_neg();
      chk("t6_restart_addr", mem_addr, 32'h100);
      chk("t6_restart_valid", 32'(out_valid), 32'd0);
      to_pos();
      step();
      out_ready = 1'b0;
      to_neg();
      chk("sb_final_drained", 32'(exp_q.size()), 32'd0);
      to_pos();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
